// File: rtl/uart_frame_decoder_if.sv
// Byte-strobe input side and decoded-frame output side of the remote-player frame decoder.
// The decoder drives the frame side from registers; the byte receiver drives the strobe side.
interface uart_frame_decoder_if #(
    parameter int unsigned PAYLOAD_LEN = 4
);
    logic                     rx_done_tick;
    logic [7:0]               rx_data;
    logic                     frame_valid;
    logic [7:0]               frame_type;
    logic [8*PAYLOAD_LEN-1:0] payload;
    logic                     chk_err;
    logic                     timeout_err;
    logic [7:0]               frame_cnt;

    modport master (
        output rx_done_tick, rx_data,
        input  frame_valid, frame_type, payload, chk_err, timeout_err, frame_cnt
    );

    modport slave (
        input  rx_done_tick, rx_data,
        output frame_valid, frame_type, payload, chk_err, timeout_err, frame_cnt
    );
endinterface

// File: rtl/uart_frame_decoder.sv
// Assembles SYNC/TYPE/payload/CHK frames from UART bytes, verifies the XOR checksum,
// and publishes good frames as registered words; corrupt or stalled frames are dropped.
module uart_frame_decoder #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned PAYLOAD_LEN    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 650000
) (
    input logic                clk,
    input logic                reset,
    uart_frame_decoder_if.slave bus
);
    localparam int unsigned IDX_W = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_HUNT,
        S_TYPE,
        S_PAYLOAD,
        S_CHECK
    } state_t;

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic [7:0]               chk;
    logic [CNT_W-1:0]         tmo_cnt;
    logic [7:0]               type_shadow;
    logic [8*PAYLOAD_LEN-1:0] shadow;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_HUNT;
            idx             <= '0;
            chk             <= '0;
            tmo_cnt         <= '0;
            type_shadow     <= '0;
            shadow          <= '0;
            bus.frame_valid <= 1'b0;
            bus.frame_type  <= '0;
            bus.payload     <= '0;
            bus.chk_err     <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.frame_cnt   <= '0;
        end else begin
            bus.frame_valid <= 1'b0;
            bus.chk_err     <= 1'b0;
            bus.timeout_err <= 1'b0;

            // A byte arriving on the expiry cycle takes priority over the timeout.
            if (bus.rx_done_tick) begin
                tmo_cnt <= '0;
                unique case (state)
                    S_HUNT: begin
                        if (bus.rx_data == SYNC_BYTE) state <= S_TYPE;
                    end
                    S_TYPE: begin
                        type_shadow <= bus.rx_data;
                        chk         <= bus.rx_data;
                        idx         <= '0;
                        state       <= S_PAYLOAD;
                    end
                    S_PAYLOAD: begin
                        for (int unsigned i = 0; i < PAYLOAD_LEN; i++) begin
                            if (idx == IDX_W'(i)) shadow[i*8 +: 8] <= bus.rx_data;
                        end
                        chk <= chk ^ bus.rx_data;
                        if (idx == IDX_W'(PAYLOAD_LEN - 1)) state <= S_CHECK;
                        else                                idx   <= idx + IDX_W'(1);
                    end
                    S_CHECK: begin
                        if (bus.rx_data == chk) begin
                            bus.frame_valid <= 1'b1;
                            bus.frame_type  <= type_shadow;
                            bus.payload     <= shadow;
                            bus.frame_cnt   <= bus.frame_cnt + 8'd1;
                        end else begin
                            bus.chk_err <= 1'b1;
                        end
                        idx   <= '0;
                        chk   <= '0;
                        state <= S_HUNT;
                    end
                    default: state <= S_HUNT;
                endcase
            end else if (state != S_HUNT) begin
                // Expiry is decided one count early so the pulse lands TIMEOUT_CYCLES after the last byte.
                if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    bus.timeout_err <= 1'b1;
                    state           <= S_HUNT;
                    idx             <= '0;
                    chk             <= '0;
                    tmo_cnt         <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule
